// File: rtl/sprite_mover.sv
// sprite_mover: sprite-movement engine for the VGA game layer.
// Clears the screen, draws a SPRITE_W x SPRITE_H sprite read from an external
// synchronous ROM, then on left/right commands erases the sprite, steps its
// x position (clamped to the screen) and redraws it at the new place.
// Plot outputs are registered; every pixel appears one cycle after it is
// scheduled. Completion pulses follow the last plotted pixel by one cycle.
// Optional build macro: SPRITE_MOVER_TRANSPARENT_EN (black sprite pixels are
// not written, so the background shows through).
module sprite_mover #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int SPRITE_W = 11,
    parameter int SPRITE_H = 10,
    parameter int X_START  = 73,
    parameter int Y_START  = 105,
    parameter int STEP     = 5,
    parameter int ADDR_W   = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              left,
    input  logic              right,
    input  logic [2:0]        rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        xout,
    output logic [6:0]        yout,
    output logic [2:0]        colourOut,
    output logic              drawEn,
    output logic              screenCleared,
    output logic              drewHomeBase,
    output logic              moveDone,
    output logic              blocked,
    output logic              busy,
    output logic [7:0]        posX
);

    localparam int PIX_N = SPRITE_W * SPRITE_H;
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  PIX_LAST   = CNT_W'(PIX_N - 1);
    localparam logic [CNT_W-1:0]  PIX_END    = CNT_W'(PIX_N);
    localparam logic [ADDR_W-1:0] ADDR_ZERO  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
    localparam logic [7:0]        CLR_X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0]        CLR_Y_LAST = 7'(SCREEN_H - 1);
    localparam logic [7:0]        SPR_C_LAST = 8'(SPRITE_W - 1);
    localparam logic [7:0]        X_MAX      = 8'(SCREEN_W - SPRITE_W);
    localparam logic [7:0]        X_INIT     = 8'(X_START);
    localparam logic [6:0]        Y_TOP      = 7'(Y_START);
    localparam logic [8:0]        STEP9      = 9'(STEP);

    typedef enum logic [2:0] {
        S_TITLE = 3'd0,
        S_CLEAR = 3'd1,
        S_HOME  = 3'd2,
        S_CMD   = 3'd3,
        S_ERASE = 3'd4,
        S_STEP  = 3'd5,
        S_DRAW  = 3'd6
    } state_t;

    // Which operation the pixel just registered finished, if any.
    typedef enum logic [1:0] {
        DONE_NONE  = 2'd0,
        DONE_CLEAR = 2'd1,
        DONE_HOME  = 2'd2,
        DONE_MOVE  = 2'd3
    } done_t;

    // Target x for one step; 9-bit arithmetic so neither direction can wrap.
    function automatic logic [7:0] step_target(input logic [7:0] pos, input logic go_left);
        logic [8:0] wide;
        logic [7:0] res;
        wide = 9'd0;
        res  = pos;
        if (go_left) begin
            if ({1'b0, pos} < STEP9) begin
                res = 8'd0;
            end else begin
                wide = {1'b0, pos} - STEP9;
                res  = wide[7:0];
            end
        end else begin
            wide = {1'b0, pos} + STEP9;
            if (wide > {1'b0, X_MAX}) begin
                res = X_MAX;
            end else begin
                res = wide[7:0];
            end
        end
        return res;
    endfunction

    state_t             state_r;
    state_t             next_state_s;
    logic [7:0]         col_r;
    logic [6:0]         row_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [7:0]         posx_r;
    logic [7:0]         target_r;
    logic [ADDR_W-1:0]  rom_addr_r;
    logic [7:0]         xout_r;
    logic [6:0]         yout_r;
    logic [2:0]         colour_r;
    logic               draw_en_r;
    done_t              done_kind_r;
    logic               screen_cleared_r;
    logic               drew_home_r;
    logic               move_done_r;
    logic               blocked_r;
    logic               busy_r;

    logic               clear_last_s;
    logic               pix_keep_s;
    logic [7:0]         cmd_target_s;
    logic               cmd_blocked_s;
    logic               cmd_go_s;

    assign clear_last_s = (col_r == CLR_X_LAST) && (row_r == CLR_Y_LAST);

`ifdef SPRITE_MOVER_TRANSPARENT_EN
    assign pix_keep_s = (rom_data != 3'd0);
`else
    assign pix_keep_s = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_TITLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and command decode (commands only looked at in S_CMD)
    always_comb begin
        next_state_s  = state_r;
        cmd_target_s  = step_target(posx_r, left);
        cmd_blocked_s = 1'b0;
        cmd_go_s      = 1'b0;
        case (state_r)
            S_TITLE: begin
                if (start) begin
                    next_state_s = S_CLEAR;
                end else begin
                    next_state_s = S_TITLE;
                end
            end
            S_CLEAR: begin
                if (clear_last_s) begin
                    next_state_s = S_HOME;
                end else begin
                    next_state_s = S_CLEAR;
                end
            end
            S_HOME, S_DRAW: begin
                if (cnt_r == PIX_END) begin
                    next_state_s = S_CMD;
                end else begin
                    next_state_s = state_r;
                end
            end
            S_CMD: begin
                if (left ^ right) begin
                    if (cmd_target_s == posx_r) begin
                        cmd_blocked_s = 1'b1;
                        next_state_s  = S_CMD;
                    end else begin
                        cmd_go_s     = 1'b1;
                        next_state_s = S_ERASE;
                    end
                end else begin
                    next_state_s = S_CMD;
                end
            end
            S_ERASE: begin
                if (cnt_r == PIX_LAST) begin
                    next_state_s = S_STEP;
                end else begin
                    next_state_s = S_ERASE;
                end
            end
            S_STEP: begin
                next_state_s = S_DRAW;
            end
            default: begin
                next_state_s = S_TITLE;
            end
        endcase
    end

    // Pixel counters, ROM address, plot registers, position and pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_r            <= 8'd0;
            row_r            <= 7'd0;
            cnt_r            <= CNT_ZERO;
            posx_r           <= X_INIT;
            target_r         <= X_INIT;
            rom_addr_r       <= ADDR_ZERO;
            xout_r           <= 8'd0;
            yout_r           <= 7'd0;
            colour_r         <= 3'd0;
            draw_en_r        <= 1'b0;
            done_kind_r      <= DONE_NONE;
            screen_cleared_r <= 1'b0;
            drew_home_r      <= 1'b0;
            move_done_r      <= 1'b0;
            blocked_r        <= 1'b0;
            busy_r           <= 1'b0;
        end else begin
            draw_en_r        <= 1'b0;
            done_kind_r      <= DONE_NONE;
            screen_cleared_r <= (done_kind_r == DONE_CLEAR);
            drew_home_r      <= (done_kind_r == DONE_HOME);
            move_done_r      <= (done_kind_r == DONE_MOVE);
            blocked_r        <= cmd_blocked_s;
            busy_r           <= (next_state_s != S_TITLE) && (next_state_s != S_CMD);
            case (state_r)
                S_CLEAR: begin
                    xout_r    <= col_r;
                    yout_r    <= row_r;
                    colour_r  <= 3'd0;
                    draw_en_r <= 1'b1;
                    if (clear_last_s) begin
                        col_r       <= 8'd0;
                        row_r       <= 7'd0;
                        done_kind_r <= DONE_CLEAR;
                    end else if (col_r == CLR_X_LAST) begin
                        col_r <= 8'd0;
                        row_r <= row_r + 7'd1;
                    end else begin
                        col_r <= col_r + 8'd1;
                    end
                end
                S_HOME, S_DRAW: begin
                    // Address runs one cycle ahead of the pixel being plotted.
                    if (cnt_r < PIX_LAST) begin
                        rom_addr_r <= rom_addr_r + ADDR_ONE;
                    end else begin
                        rom_addr_r <= ADDR_ZERO;
                    end
                    if (cnt_r != CNT_ZERO) begin
                        xout_r    <= posx_r + col_r;
                        yout_r    <= Y_TOP + row_r;
                        colour_r  <= rom_data;
                        draw_en_r <= pix_keep_s;
                    end
                    if (cnt_r == PIX_END) begin
                        cnt_r       <= CNT_ZERO;
                        col_r       <= 8'd0;
                        row_r       <= 7'd0;
                        done_kind_r <= (state_r == S_HOME) ? DONE_HOME : DONE_MOVE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                        if (cnt_r != CNT_ZERO) begin
                            if (col_r == SPR_C_LAST) begin
                                col_r <= 8'd0;
                                row_r <= row_r + 7'd1;
                            end else begin
                                col_r <= col_r + 8'd1;
                            end
                        end
                    end
                end
                S_ERASE: begin
                    xout_r    <= posx_r + col_r;
                    yout_r    <= Y_TOP + row_r;
                    colour_r  <= 3'd0;
                    draw_en_r <= 1'b1;
                    if (cnt_r == PIX_LAST) begin
                        cnt_r <= CNT_ZERO;
                        col_r <= 8'd0;
                        row_r <= 7'd0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                        if (col_r == SPR_C_LAST) begin
                            col_r <= 8'd0;
                            row_r <= row_r + 7'd1;
                        end else begin
                            col_r <= col_r + 8'd1;
                        end
                    end
                end
                S_STEP: begin
                    posx_r <= target_r;
                end
                S_CMD: begin
                    if (cmd_go_s) begin
                        target_r <= cmd_target_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rom_addr      = rom_addr_r;
    assign xout          = xout_r;
    assign yout          = yout_r;
    assign colourOut     = colour_r;
    assign drawEn        = draw_en_r;
    assign screenCleared = screen_cleared_r;
    assign drewHomeBase  = drew_home_r;
    assign moveDone      = move_done_r;
    assign blocked       = blocked_r;
    assign busy          = busy_r;
    assign posX          = posx_r;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed, table-driven bench for sprite_mover with default parameters.
module tb_sprite_mover;

    localparam int PIX = 110;
`ifdef SPRITE_MOVER_TRANSPARENT_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif
    localparam int SPR_PLOTS = TRANSP ? 108 : 110;

    logic       clk = 1'b0;
    logic       reset, start, left, right;
    logic [2:0] rom_data = 3'd0;
    logic [6:0] rom_addr;
    logic [7:0] xout, posX;
    logic [6:0] yout;
    logic [2:0] colourOut;
    logic       drawEn, screenCleared, drewHomeBase, moveDone, blocked, busy;

    sprite_mover dut (
        .clk(clk), .reset(reset), .start(start), .left(left), .right(right),
        .rom_data(rom_data), .rom_addr(rom_addr), .xout(xout), .yout(yout),
        .colourOut(colourOut), .drawEn(drawEn), .screenCleared(screenCleared),
        .drewHomeBase(drewHomeBase), .moveDone(moveDone), .blocked(blocked),
        .busy(busy), .posX(posX)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] x; logic [6:0] y; logic [2:0] c; } plot_t;
    typedef struct { logic l; logic r; int exp_pos; logic exp_blk; logic exp_move; } vec_t;

    plot_t plots[$];
    int    total = 0;
    int    bad   = 0;
    int    model_pos;

    function automatic logic [2:0] rom_val(input int a);
        if (a == 0 || a == 109) return 3'd0;
        return 3'((a % 7) + 1);
    endfunction

    // synchronous sprite ROM model
    always @(posedge clk) rom_data <= rom_val(int'(rom_addr));

    // plot capture
    always @(negedge clk) begin
        plot_t p;
        if (drawEn) begin
            p.x = xout; p.y = yout; p.c = colourOut;
            plots.push_back(p);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_pulse(input int which, input int bound, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        while (n <= bound && !ok) begin
            @(negedge clk);
            case (which)
                0: ok = screenCleared;
                1: ok = drewHomeBase;
                default: ok = moveDone;
            endcase
            if (!ok) n++;
        end
    endtask

    // compare a run of plots against a sprite (ROM colours) or erase (black) rectangle
    task automatic check_rect(input string name, input int base, input int x0,
                              input bit sprite, output int next);
        int idx = base;
        int errs = 0;
        for (int i = 0; i < PIX; i++) begin
            int ec = sprite ? int'(rom_val(i)) : 0;
            if (sprite && TRANSP && ec == 0) continue;
            if (idx >= plots.size()) begin
                errs++;
                break;
            end
            if (int'(plots[idx].x) != x0 + i % 11 || int'(plots[idx].y) != 105 + i / 11 ||
                int'(plots[idx].c) != ec) errs++;
            idx++;
        end
        chk(name, errs, 0);
        next = idx;
    endtask

    task automatic check_move(input int old_x, input int new_x);
        int n1, n2;
        chk("move_plot_count", plots.size(), PIX + SPR_PLOTS);
        check_rect("erase_pixels", 0, old_x, 1'b0, n1);
        check_rect("draw_pixels", n1, new_x, 1'b1, n2);
    endtask

    task automatic apply_vec(input vec_t v);
        int n;
        bit ok;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_before_cmd", int'(busy), 0);
        left = v.l; right = v.r;
        plots.delete();
        @(posedge clk);
        #1;
        left = 1'b0; right = 1'b0;
        if (v.exp_move) begin
            wait_pulse(2, 400, n, ok);
            chk("move_done_seen", int'(ok), 1);
            chk("move_cycles", n, 223);
            chk("move_posX", int'(posX), v.exp_pos);
            check_move(model_pos, v.exp_pos);
        end else begin
            @(negedge clk);
            chk("blocked_pulse", int'(blocked), int'(v.exp_blk));
            repeat (5) @(negedge clk);
            chk("blocked_after", int'(blocked), 0);
            chk("no_plot_plots", plots.size(), 0);
            chk("hold_posX", int'(posX), v.exp_pos);
            chk("hold_busy", int'(busy), 0);
        end
        model_pos = v.exp_pos;
    endtask

    initial begin
        vec_t tab1[6];
        vec_t tab2[3];
        int   n, n2, exp, cnt, errs;
        bit   ok;

        tab1[0] = '{1'b0, 1'b1, 78, 1'b0, 1'b1};
        tab1[1] = '{1'b1, 1'b1, 78, 1'b0, 1'b0};
        tab1[2] = '{1'b0, 1'b0, 78, 1'b0, 1'b0};
        tab1[3] = '{1'b1, 1'b0, 73, 1'b0, 1'b1};
        tab1[4] = '{1'b0, 1'b1, 78, 1'b0, 1'b1};
        tab1[5] = '{1'b1, 1'b0, 73, 1'b0, 1'b1};
        tab2[0] = '{1'b0, 1'b1, 149, 1'b1, 1'b0};
        tab2[1] = '{1'b1, 1'b0, 144, 1'b0, 1'b1};
        tab2[2] = '{1'b0, 1'b1, 149, 1'b0, 1'b1};

        reset = 1'b0; start = 1'b0; left = 1'b0; right = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_posX", int'(posX), 73);
        chk("rst_drawEn", int'(drawEn), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_pulses", int'({screenCleared, drewHomeBase, moveDone, blocked}), 0);

        // start a clear, then reset in the middle of it
        reset = 1'b1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (300) @(negedge clk);
        chk("clear_busy", int'(busy), 1);
        chk("clear_drawEn", int'(drawEn), 1);
        chk("clear_row1", int'(yout), 1);
        reset = 1'b0;
        #1;
        chk("midrst_xout", int'(xout), 0);
        chk("midrst_yout", int'(yout), 0);
        chk("midrst_drawEn", int'(drawEn), 0);
        chk("midrst_busy", int'(busy), 0);
        plots.delete();
        @(negedge clk); reset = 1'b1;

        // title ignores move commands
        left = 1'b1;
        repeat (10) @(negedge clk);
        left = 1'b0;
        chk("title_busy", int'(busy), 0);
        chk("title_posX", int'(posX), 73);
        chk("title_no_plots", plots.size(), 0);

        // full clear and home draw
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        plots.delete();
        wait_pulse(0, 20000, n, ok);
        chk("clear_pulse_seen", int'(ok), 1);
        chk("clear_cycles", n, 19201);
        chk("clear_plot_count", plots.size(), 19200);
        errs = 0;
        for (int i = 0; i < plots.size() && i < 19200; i++) begin
            if (int'(plots[i].x) != i % 160 || int'(plots[i].y) != i / 160 || plots[i].c != 3'd0)
                errs++;
        end
        chk("clear_raster", errs, 0);
        plots.delete();
        wait_pulse(1, 300, n, ok);
        chk("home_pulse_seen", int'(ok), 1);
        chk("home_cycles", n, 110);
        chk("home_plot_count", plots.size(), SPR_PLOTS);
        check_rect("home_pixels", 0, 73, 1'b1, n2);
        @(negedge clk);
        chk("home_pulse_width", int'(drewHomeBase), 0);
        model_pos = 73;

        for (int i = 0; i < 6; i++) apply_vec(tab1[i]);

        // held left: auto-repeat down to the left bound
        plots.delete();
        left = 1'b1;
        exp = model_pos;
        for (int k = 0; k < 15; k++) begin
            n2 = (exp - 5 < 0) ? 0 : exp - 5;
            wait_pulse(2, 400, n, ok);
            chk("hl_seen", int'(ok), 1);
            if (!ok) break;
            chk("hl_posX", int'(posX), n2);
            check_move(exp, n2);
            plots.delete();
            exp = n2;
        end
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (blocked) cnt++;
        end
        chk("hl_blocked_cycles", cnt, 20);
        left = 1'b0;
        repeat (2) @(negedge clk);
        chk("hl_blocked_release", int'(blocked), 0);
        chk("hl_no_plots", plots.size(), 0);
        chk("hl_final_posX", int'(posX), 0);

        // held right: auto-repeat up to the right bound (145 -> 149 clamps)
        right = 1'b1;
        exp = 0;
        for (int k = 0; k < 30; k++) begin
            n2 = (exp + 5 > 149) ? 149 : exp + 5;
            wait_pulse(2, 400, n, ok);
            chk("hr_seen", int'(ok), 1);
            if (!ok) break;
            chk("hr_posX", int'(posX), n2);
            check_move(exp, n2);
            plots.delete();
            exp = n2;
        end
        repeat (5) @(negedge clk);
        chk("hr_blocked", int'(blocked), 1);
        right = 1'b0;
        repeat (2) @(negedge clk);
        chk("hr_no_plots", plots.size(), 0);
        model_pos = 149;

        for (int i = 0; i < 3; i++) apply_vec(tab2[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global time limit
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
